// File: rtl/acc_seq_pkg.sv
// Shared definitions for the operand accumulator sequencer: default sizes,
// FSM state encoding and the add/subtract opcode values.
`timescale 1ns/1ps
package acc_seq_pkg;

  localparam int ACC_WIDTH_DEF   = 4;
  localparam int ACC_MAX_OPS_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/acc_seq_addsub.sv
// Combinational WIDTH-bit add/subtract. The extra top bit of res is the
// carry on add, or the borrow on subtract (set exactly when a < b).
`timescale 1ns/1ps
module addsub_core
  import acc_seq_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH:0]   res
);

  // Zero-extend both operands so the top bit captures carry/borrow.
  always_comb begin
    if (op == OP_SUB) begin
      res = {1'b0, a} - {1'b0, b};
    end else begin
      res = {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/acc_seq.sv
// Operand accumulator sequencer: after start, accepts a stream of operand
// beats, folds them into a running sum/difference with a sticky carry/borrow
// flag, and presents the result until the consumer takes it.
`timescale 1ns/1ps
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int WIDTH   = ACC_WIDTH_DEF,
  parameter int MAX_OPS = ACC_MAX_OPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sign,
  output logic [3:0]       out_count,
  output logic             busy
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             ovf_reg;
  logic [3:0]       count_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [WIDTH:0]   addsub_res;
  logic [3:0]       count_inc;
  logic             ops_full;
  logic             first_is_last;

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (acc_reg),
    .b   (in_data),
    .op  (in_op),
    .res (addsub_res)
  );

  assign count_inc     = count_reg + 4'd1;
  // The beat being accepted in ACC is the MAX_OPS-th operand.
  assign ops_full      = (count_inc == 4'(MAX_OPS));
  // A degenerate one-operand limit ends the sequence on the first beat.
  assign first_is_last = in_last || (MAX_OPS == 1);

  // Sequencer FSM; handshake flags are registered alongside the state so
  // they always agree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      count_reg     <= 4'd0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            acc_reg   <= in_data;
            ovf_reg   <= 1'b0;
            count_reg <= 4'd1;
            if (first_is_last) begin
              state_reg     <= ST_DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc_reg   <= addsub_res[WIDTH-1:0];
            ovf_reg   <= ovf_reg | addsub_res[WIDTH];
            count_reg <= count_inc;
            if (in_last || ops_full) begin
              state_reg     <= ST_DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here; a new sequence must
          // be requested from IDLE.
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign out_acc   = acc_reg;
  assign out_ovf   = ovf_reg;
  assign out_count = count_reg;
  assign out_zero  = (acc_reg == '0);
  assign out_sign  = acc_reg[WIDTH-1];

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/accumulator width in bits.
REQ-002 Parameter MAX_OPS, default 8, maximum operands per sequence (first operand included).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a new sequence; sampled only in IDLE.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_data  input  WIDTH  operand value, unsigned.
REQ-008 in_op  input  1  0 = add, 1 = subtract; ignored on first beat.
REQ-009 in_last  input  1  marks final operand of the sequence.
REQ-010 in_ready  output  1  block accepts an operand this cycle.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_acc  output  WIDTH  accumulated result, modulo 2^WIDTH.
REQ-014 out_ovf  output  1  sticky carry/borrow over the sequence.
REQ-015 out_zero  output  1  out_acc == 0.
REQ-016 out_sign  output  1  out_acc[WIDTH-1].
REQ-017 out_count  output  4  operands accepted in the current/last sequence.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, LOAD, ACC, DONE; IDLE->LOAD on start; start ignored outside IDLE.
REQ-020 Operand transfer occurs on a cycle with in_valid & in_ready; in_ready = 1 only in LOAD and ACC.
REQ-021 LOAD transfer: acc <= in_data, ovf <= 0, count <= 1; -> DONE if in_last, else -> ACC.
REQ-022 ACC transfer: {c, acc} <= {0,acc} + {0,in_data} (in_op=0) or {0,acc} - {0,in_data} (in_op=1), a (WIDTH+1)-bit operation; ovf <= ovf | c; count <= count + 1.
REQ-023 Borrow is c = 1 exactly when acc < in_data on subtract; carry is c = 1 exactly when sum >= 2^WIDTH on add.
REQ-024 ACC -> DONE on a transfer with in_last = 1, or on the transfer that makes count == MAX_OPS regardless of in_last.
REQ-025 No transfer (in_valid = 0) in LOAD/ACC: all state held.
REQ-026 DONE: out_valid = 1, outputs stable; DONE -> IDLE on out_ready = 1; held indefinitely while out_ready = 0.
REQ-027 out_valid asserts the cycle after the final operand transfer (latency 1).
REQ-028 out_acc, out_ovf, out_count driven from registers at all times; out_zero, out_sign combinational from acc.
REQ-029 start asserted in the same cycle DONE->IDLE is ignored; new sequence needs start in IDLE.

Reset
REQ-030 rst_n low, any state, any cycle: state = IDLE, acc = 0, ovf = 0, count = 0 immediately, without a clock.
REQ-031 Reset values: in_ready 0, out_valid 0, busy 0, out_acc 0, out_ovf 0, out_zero 1, out_sign 0, out_count 0.
REQ-032 Reset mid-sequence discards partial result; no out_valid produced for it.

Structure
REQ-033 Package acc_seq_pkg holds WIDTH/MAX_OPS defaults, state enum, OP_ADD = 0 / OP_SUB = 1 constants.
REQ-034 One sub-module addsub_core: combinational WIDTH-bit add/sub returning {c, result}, instantiated once in acc_seq.

Verification
REQ-035 start; beats 3, +5, +2(last) -> out_valid next cycle, out_acc 10, out_ovf 0, out_sign 1, out_zero 0, out_count 3.
REQ-036 start; beats 9, +8(last) -> out_acc 1, out_ovf 1, out_count 2.
REQ-037 start; beats 3, -5(last) -> out_acc 14, out_ovf 1, out_sign 1; beats 5, -5(last) -> out_acc 0, out_zero 1, out_ovf 0.
REQ-038 start; eight beats of +1 (first = 1), in_last never set -> DONE after 8th, out_acc 8, out_count 8, in_ready 0.
REQ-039 Result 7 with out_ready low 5 cycles -> out_valid and outputs stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-040 rst_n low after 2 of 3 beats -> immediate IDLE, out_acc 0, out_zero 1; next start + single beat 4(last) -> out_acc 4, out_count 1.
